// File: rtl/masked_random_source_pkg.sv
// Shared types and helpers for the masked S-box randomness source.
// Lane arithmetic (xorshift32 step, lane seeding) and bit/lane sizing functions.
package masked_random_source_pkg;

    typedef logic [31:0] rand_lane_t;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUNNING  = 2'd2
    } src_state_t;

    localparam rand_lane_t LANE_GOLDEN = 32'h9E3779B9;

    // Fresh bits per masked inverter: 18 per pair of shares (DOM GF(2^8) inversion).
    function automatic int num_inv_random(input int num_shares);
        return 18 * ((num_shares * (num_shares - 1)) / 2);
    endfunction

    function automatic int num_rand_lanes(input int num_shares, input int num_consumers);
        return (num_consumers * num_inv_random(num_shares) + 31) / 32;
    endfunction

    function automatic rand_lane_t xorshift32_step(input rand_lane_t x);
        rand_lane_t y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Per-lane decorrelation of the single seed word; zero is replaced inside the lane.
    function automatic rand_lane_t lane_seed(input rand_lane_t seed, input int idx);
        rand_lane_t mult;
        mult = LANE_GOLDEN * rand_lane_t'(idx + 1);
        return seed ^ mult;
    endfunction

endpackage

// File: rtl/masked_random_source_xorshift32_lane.sv
// One xorshift32 lane register with load / step / hold control.
// A zero load value is replaced by 1 because zero is the generator's fixed point.
module xorshift32_lane
    import masked_random_source_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic       i_step,
    input  rand_lane_t i_seed,
    output rand_lane_t o_state
);

    rand_lane_t r_state;

    // Lane state: reset clears, load has priority over step, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= 32'd0;
        end else if (i_load) begin
            r_state <= (i_seed == 32'd0) ? 32'd1 : i_seed;
        end else if (i_step) begin
            r_state <= xorshift32_step(r_state);
        end else begin
            r_state <= r_state;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/masked_random_source.sv
// Randomness producer for the masked S-box array: seeded xorshift32 lanes with warmup.
// Optional sticky health check enabled by defining MASKED_RANDOM_HEALTH_EN.
module masked_random_source
    import masked_random_source_pkg::*;
#(
    parameter  int NUM_SHARES    = 2,
    parameter  int NUM_CONSUMERS = 4,
    parameter  int WARMUP_CYCLES = 4,
    localparam int OUT_BITS      = NUM_CONSUMERS * num_inv_random(NUM_SHARES)
) (
    input  logic                in_clock,
    input  logic                in_reset,
    input  logic [31:0]         in_seed,
    input  logic                in_seed_valid,
    input  logic                in_enable,
    output logic [OUT_BITS-1:0] out_random,
    output logic                out_valid,
    output logic                out_error
);

    localparam int         LANES      = num_rand_lanes(NUM_SHARES, NUM_CONSUMERS);
    localparam logic [7:0] WARM_LIMIT = 8'(WARMUP_CYCLES);

    src_state_t            r_state;
    src_state_t            w_state_next;
    logic [7:0]            r_warm_cnt;
    logic [7:0]            w_warm_cnt_next;
    logic                  w_load;
    logic                  w_step;
    logic                  r_valid;
    logic                  r_error;
    logic                  w_error_next;
    rand_lane_t            w_lane [LANES];
    logic [LANES*32-1:0]   w_lanes_flat;
    logic                  w_unused_lane_bits;

    // Next-state, warmup counting and lane step/load control; a seed beats everything.
    always_comb begin
        w_state_next    = r_state;
        w_warm_cnt_next = r_warm_cnt;
        w_load          = in_seed_valid;
        w_step          = 1'b0;
        if (in_seed_valid) begin
            w_warm_cnt_next = 8'd0;
            w_state_next    = (WARM_LIMIT == 8'd0) ? ST_RUNNING : ST_WARMUP;
        end else begin
            case (r_state)
                ST_UNSEEDED: begin
                    w_state_next = ST_UNSEEDED;
                end
                ST_WARMUP: begin
                    w_step = 1'b1;
                    if (r_warm_cnt < WARM_LIMIT) begin
                        w_warm_cnt_next = r_warm_cnt + 8'd1;
                    end else begin
                        w_warm_cnt_next = r_warm_cnt;
                    end
                    if ((r_warm_cnt + 8'd1) >= WARM_LIMIT) begin
                        w_state_next = ST_RUNNING;
                    end else begin
                        w_state_next = ST_WARMUP;
                    end
                end
                ST_RUNNING: begin
                    w_step = in_enable;
                end
                default: begin
                    w_state_next = ST_UNSEEDED;
                end
            endcase
        end
    end

`ifdef MASKED_RANDOM_HEALTH_EN
    logic w_fault;

    // Health check: a seeded lane must never be zero nor stall while stepping.
    always_comb begin
        w_fault = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if ((r_state != ST_UNSEEDED) && (w_lane[i] == 32'd0)) begin
                w_fault = 1'b1;
            end else if (w_step && (xorshift32_step(w_lane[i]) == w_lane[i])) begin
                w_fault = 1'b1;
            end else begin
                w_fault = w_fault;
            end
        end
        w_error_next = in_seed_valid ? 1'b0 : (r_error | w_fault);
    end
`else
    assign w_error_next = 1'b0;
`endif

    // Control registers; out_valid is registered from the next-state decode.
    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            r_state    <= ST_UNSEEDED;
            r_warm_cnt <= 8'd0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_warm_cnt <= w_warm_cnt_next;
            r_valid    <= (w_state_next == ST_RUNNING) && !w_error_next;
            r_error    <= w_error_next;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        xorshift32_lane u_lane (
            .i_clk     (in_clock),
            .i_reset_n (in_reset),
            .i_load    (w_load),
            .i_step    (w_step),
            .i_seed    (lane_seed(in_seed, gi)),
            .o_state   (w_lane[gi])
        );
        assign w_lanes_flat[gi*32 +: 32] = w_lane[gi];
    end

    // Lanes beyond OUT_BITS are generated but dropped by the truncation.
    assign w_unused_lane_bits = ^w_lanes_flat;

    assign out_random = w_lanes_flat[OUT_BITS-1:0];
    assign out_valid  = r_valid;
    assign out_error  = r_error;

endmodule

// File: tb/tb_masked_random_source.sv
// Directed scoreboard bench for masked_random_source, run side by side with
// WARMUP_CYCLES = 0 (dut0) and WARMUP_CYCLES = 4 (dut4) sharing one stimulus stream.
module tb_masked_random_source;
    import masked_random_source_pkg::*;

    localparam int OB = 4 * num_inv_random(2);

    logic          clk = 1'b0;
    logic          in_reset;
    logic [31:0]   in_seed;
    logic          in_seed_valid;
    logic          in_enable;
    logic [OB-1:0] r0, r4;
    logic          v0, v4, e0, e4;

    always #5 clk = ~clk;

    masked_random_source #(.NUM_SHARES(2), .NUM_CONSUMERS(4), .WARMUP_CYCLES(0)) dut0 (
        .in_clock(clk), .in_reset(in_reset), .in_seed(in_seed), .in_seed_valid(in_seed_valid),
        .in_enable(in_enable), .out_random(r0), .out_valid(v0), .out_error(e0)
    );

    masked_random_source #(.NUM_SHARES(2), .NUM_CONSUMERS(4), .WARMUP_CYCLES(4)) dut4 (
        .in_clock(clk), .in_reset(in_reset), .in_seed(in_seed), .in_seed_valid(in_seed_valid),
        .in_enable(in_enable), .out_random(r4), .out_valid(v4), .out_error(e4)
    );

    typedef struct {
        string       tag;
        int unsigned dut;
        logic [OB+1:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m0 [3];
    logic [31:0] m4 [3];

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        logic [31:0] a, b;
        a = x ^ {x[18:0], 13'd0};
        b = a ^ {17'd0, a[31:17]};
        return b ^ {b[26:0], 5'd0};
    endfunction

    function automatic logic [31:0] ref_seed(input logic [31:0] s, input int idx);
        logic [31:0] g, v;
        g = 32'd0;
        for (int k = 0; k <= idx; k++) g = g + 32'h9E3779B9;
        v = s ^ g;
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    task automatic seed_models(input logic [31:0] s);
        for (int i = 0; i < 3; i++) begin
            m0[i] = ref_seed(s, i);
            m4[i] = ref_seed(s, i);
        end
    endtask

    task automatic step0();
        for (int i = 0; i < 3; i++) m0[i] = ref_step(m0[i]);
    endtask

    task automatic step4();
        for (int i = 0; i < 3; i++) m4[i] = ref_step(m4[i]);
    endtask

    task automatic clear_models();
        for (int i = 0; i < 3; i++) begin
            m0[i] = 32'd0;
            m4[i] = 32'd0;
        end
    endtask

    task automatic push(input string tag, input int unsigned dut, input logic valid, input logic err);
        logic [95:0] flat;
        exp_t        e;
        flat  = (dut == 0) ? {m0[2], m0[1], m0[0]} : {m4[2], m4[1], m4[0]};
        e.tag = tag;
        e.dut = dut;
        e.exp = {flat[OB-1:0], valid, err};
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t          e;
        logic [OB+1:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.dut == 0) ? {r0, v0, e0} : {r4, v4, e4};
            n_tests++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s dut%0d: got %h expected %h", e.tag, e.dut, obs, e.exp);
            end
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        in_reset      = 1'b0;
        in_seed       = 32'd0;
        in_seed_valid = 1'b0;
        in_enable     = 1'b0;
        clear_models();

        // 1: reset, then no seed -> never valid
        repeat (2) begin
            push("reset", 0, 1'b0, 1'b0);
            push("reset", 4, 1'b0, 1'b0);
            tick();
        end
        in_reset  = 1'b1;
        in_enable = 1'b1;
        repeat (20) begin
            push("unseeded", 0, 1'b0, 1'b0);
            push("unseeded", 4, 1'b0, 1'b0);
            tick();
        end

        // 2 + 4: seed 9E3779B8, lane 0 pre-image 1
        in_enable     = 1'b0;
        in_seed       = 32'h9E3779B8;
        in_seed_valid = 1'b1;
        seed_models(32'h9E3779B8);
        push("seed_load", 0, 1'b1, 1'b0);
        push("seed_load", 4, 1'b0, 1'b0);
        tick();
        chk32("lane0_seed1", r0[31:0], 32'h00000001);
        in_seed_valid = 1'b0;
        in_enable     = 1'b1;
        step0();
        step4();
        push("first_step", 0, 1'b1, 1'b0);
        push("warm1", 4, 1'b0, 1'b0);
        tick();
        chk32("lane0_step1", r0[31:0], 32'h00042021);
        in_enable = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            if (k <= 4) step4();
            push("hold", 0, 1'b1, 1'b0);
            push("warmup", 4, (k >= 4), 1'b0);
            tick();
        end
        chk32("lane0_hold", r0[31:0], 32'h00042021);

        // 3: seed whose lane 0 pre-image is zero
        in_seed       = 32'h9E3779B9;
        in_seed_valid = 1'b1;
        seed_models(32'h9E3779B9);
        push("zero_seed", 0, 1'b1, 1'b0);
        push("zero_seed", 4, 1'b0, 1'b0);
        tick();
        chk32("zero_sub0", r0[31:0], 32'h00000001);
        chk32("zero_sub4", r4[31:0], 32'h00000001);
        in_seed_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step4();
            push("hold2", 0, 1'b1, 1'b0);
            push("warmup2", 4, (k == 4), 1'b0);
            tick();
        end

        // 5: reseed in RUNNING with enable in the same cycle
        in_enable = 1'b1;
        repeat (2) begin
            step0();
            step4();
            push("run", 0, 1'b1, 1'b0);
            push("run", 4, 1'b1, 1'b0);
            tick();
        end
        in_seed       = 32'h12345678;
        in_seed_valid = 1'b1;
        seed_models(32'h12345678);
        push("reseed", 0, 1'b1, 1'b0);
        push("reseed", 4, 1'b0, 1'b0);
        tick();
        in_seed_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step0();
            step4();
            push("after_reseed", 0, 1'b1, 1'b0);
            push("after_reseed", 4, (k >= 4), 1'b0);
            tick();
        end

        // reset mid-run discards state
        in_reset = 1'b0;
        clear_models();
        push("mid_reset", 0, 1'b0, 1'b0);
        push("mid_reset", 4, 1'b0, 1'b0);
        tick();
        in_reset = 1'b1;
        repeat (3) begin
            push("post_reset", 0, 1'b0, 1'b0);
            push("post_reset", 4, 1'b0, 1'b0);
            tick();
        end

        in_enable     = 1'b0;
        in_seed       = 32'hCAFEF00D;
        in_seed_valid = 1'b1;
        seed_models(32'hCAFEF00D);
        push("seed3", 0, 1'b1, 1'b0);
        push("seed3", 4, 1'b0, 1'b0);
        tick();
        in_seed_valid = 1'b0;

`ifdef MASKED_RANDOM_HEALTH_EN
        // 6: forced zero lane trips the sticky fault until a seed load
        force dut0.g_lane[0].u_lane.r_state = 32'h0;
        m0[0] = 32'd0;
        repeat (2) begin
            step4();
            push("health_err", 0, 1'b0, 1'b1);
            push("health_other", 4, 1'b0, 1'b0);
            tick();
        end
        release dut0.g_lane[0].u_lane.r_state;
        in_seed       = 32'h0BADBEEF;
        in_seed_valid = 1'b1;
        seed_models(32'h0BADBEEF);
        push("health_clear", 0, 1'b1, 1'b0);
        push("health_clear", 4, 1'b0, 1'b0);
        tick();
        in_seed_valid = 1'b0;
`else
        repeat (2) begin
            step4();
            push("no_health", 0, 1'b1, 1'b0);
            push("no_health", 4, 1'b0, 1'b0);
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/masked_random_source.md
Name: masked_random_source

Overview:
- Producer side of the randomness interface consumed by the masked S-boxes.
- Generates fresh random bits every cycle for NUM_CONSUMERS masked S-box instances. Each instance receives num_inv_random(NUM_SHARES) bits.
- Seeded from outside, warmed up internally, then advanced one step per consumer enable.
- Sits beside the S-box array in the AES datapath. Its out_random is sliced into the per-S-box in_random buses.

Parameters:
- NUM_SHARES, 2, masking order + 1; sets bits per consumer via num_inv_random(NUM_SHARES).
- NUM_CONSUMERS, 4, number of S-box instances fed.
- WARMUP_CYCLES, 4, generator steps discarded after each seed; range 0..255.

Ports:
- in_clock  input  1  clock; all state updates on rising edge.
- in_reset  input  1  synchronous, active-low reset.
- in_seed  input  32  seed word.
- in_seed_valid  input  1  load in_seed this cycle.
- in_enable  input  1  consumer took the current word; advance.
- out_random  output  OUT_BITS  random bits; OUT_BITS = NUM_CONSUMERS*num_inv_random(NUM_SHARES).
- out_valid  output  1  out_random is fresh and usable.
- out_error  output  1  health fault flag; constant 0 unless the optional feature is enabled.

Behaviour:
- Lanes: LANES = ceil(OUT_BITS/32) independent 32-bit xorshift32 lanes.
- Step function: x ^= x<<13; x ^= x>>17; x ^= x<<5 (all mod 2^32).
- out_random = concatenation of lanes (lane 0 in bits [31:0]), truncated to OUT_BITS. It is driven directly from registered state, with no combinational path from inputs.
- Seeding: lane i = in_seed ^ (LANE_GOLDEN*(i+1) mod 2^32), with LANE_GOLDEN = 32'h9E3779B9. If the result is 0, the lane loads 32'h00000001 instead.
- FSM states and transitions:
  - UNSEEDED (reset state). On in_seed_valid, load the lanes; go to WARMUP, or to RUNNING if WARMUP_CYCLES = 0.
  - WARMUP: step all lanes every cycle and count steps. After WARMUP_CYCLES steps, go to RUNNING. in_enable is ignored.
  - RUNNING: out_valid = 1. Lanes step only in cycles where in_enable = 1; otherwise they hold.
- Reseed: in_seed_valid in any state reloads the lanes, clears the warmup counter and re-enters WARMUP (or RUNNING if WARMUP_CYCLES = 0). in_seed_valid has priority over in_enable in the same cycle.
- out_valid is low in UNSEEDED and WARMUP, and in the cycle immediately following a seed load when WARMUP_CYCLES > 0.
- Reset: state = UNSEEDED, all lanes = 0, warmup counter = 0. Hence out_random = 0, out_valid = 0, out_error = 0. A reset mid-warmup or mid-run discards everything; a fresh seed is required.
- Warmup counter is 8 bits and saturates at WARMUP_CYCLES; it does not wrap.

Optional Feature:
- Macro: MASKED_RANDOM_HEALTH_EN.
- When defined: each cycle, every lane is checked for 0 and for state == previous-cycle state while stepping. Either condition sets out_error.
  - out_error is sticky and forces out_valid = 0.
  - It is cleared only by reset or by a seed load.
- When undefined: out_error is tied to 0 and the check logic is absent.

Decomposition:
- Add to aes128_package:
  - rand_lane_t (32-bit vector type);
  - LANE_GOLDEN constant;
  - function xorshift32_step;
  - function num_rand_lanes(NUM_SHARES, NUM_CONSUMERS).
  - num_inv_random is already in the package and is reused as-is.
- One sub-module: xorshift32_lane. It holds one lane register with load/step/hold controls and the zero-substitute on load.
- The top level holds the FSM, the warmup counter, concatenation/truncation and the optional health logic.

Test Plan:
1. Reset, with in_reset = 0 held for 2 cycles -> out_random = 0, out_valid = 0, out_error = 0. With no seed, out_valid stays 0 for 20 cycles despite in_enable = 1.
2. WARMUP_CYCLES = 0, seed 32'h9E3779B8 -> next cycle lane 0 = 32'h00000001 and out_valid = 1. After one in_enable, lane 0 = 32'h00042021. With in_enable = 0 for 5 cycles, lane 0 holds 32'h00042021.
3. Seed 32'h9E3779B9 (lane 0 pre-image is 0) -> lane 0 loads 32'h00000001, not 0.
4. WARMUP_CYCLES = 4 -> out_valid rises exactly 5 cycles after the seed cycle. Lane 0 equals the reference model's xorshift32 applied 4 times to the seeded value.
5. Reseed in RUNNING with in_enable = 1 in the same cycle -> the seed wins, out_valid drops for WARMUP_CYCLES cycles, and the sequence restarts from the new seed.
6. With MASKED_RANDOM_HEALTH_EN: force lane 0 to 0 via the bench -> out_error = 1 and out_valid = 0 next cycle. Both remain until a seed load, which clears out_error.
